// File: rtl/key_cmd_decoder.sv
// Four-key press decoder: per-key SHORT/LONG/REPEAT/LONG_REL event FSMs feeding
// one-entry pending registers, a fixed-priority arbiter and a 4-deep command FIFO.
module key_cmd_decoder #(
    parameter logic [31:0] LONG_CNT   = 32'd50_000_000,
    parameter logic [31:0] REPEAT_CNT = 32'd10_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_flag0,
    input  logic       key_flag1,
    input  logic       key_flag2,
    input  logic       key_flag3,
    input  logic       key_value0,
    input  logic       key_value1,
    input  logic       key_value2,
    input  logic       key_value3,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [3:0] cmd_code,
    output logic [2:0] cmd_level,
    output logic       evt_drop
);

    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} key_state_t;
    typedef enum logic [1:0] {EV_SHORT = 2'b00, EV_LONG = 2'b01,
                              EV_REPEAT = 2'b10, EV_LONG_REL = 2'b11} evt_t;

    logic [3:0]  flag;
    logic [3:0]  value;
    key_state_t  state_q [4];
    key_state_t  state_d [4];
    logic [31:0] cnt_q   [4];
    logic [31:0] cnt_d   [4];
    logic [3:0]  emit;
    evt_t        etype   [4];

    logic [3:0]  pend_v;
    logic [3:0]  pend_code [4];
    logic [3:0]  drain;
    logic        push;
    logic [1:0]  sel;
    logic        pop;
    logic        drop_any;

    logic [3:0]  mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  level;

    assign flag  = {key_flag3, key_flag2, key_flag1, key_flag0};
    assign value = {key_value3, key_value2, key_value1, key_value0};

    // Release is checked before the counter terminal value so it wins a tie.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            emit[i]    = 1'b0;
            etype[i]   = EV_SHORT;
            case (state_q[i])
                ST_IDLE: begin
                    if (flag[i] && !value[i]) begin
                        state_d[i] = ST_HELD;
                        cnt_d[i]   = '0;
                    end
                end
                ST_HELD: begin
                    if (flag[i] && value[i]) begin
                        emit[i]    = 1'b1;
                        etype[i]   = EV_SHORT;
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == LONG_CNT - 32'd1) begin
                        emit[i]    = 1'b1;
                        etype[i]   = EV_LONG;
                        state_d[i] = ST_LONG;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 32'd1;
                    end
                end
                ST_LONG: begin
                    if (flag[i] && value[i]) begin
                        emit[i]    = 1'b1;
                        etype[i]   = EV_LONG_REL;
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == REPEAT_CNT - 32'd1) begin
                        emit[i]  = 1'b1;
                        etype[i] = EV_REPEAT;
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 32'd1;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Arbiter looks at the pre-pop level, so a pop never frees room for a same-cycle push.
    always_comb begin
        push  = 1'b0;
        sel   = 2'd0;
        drain = '0;
        if (level < 3'd4) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (pend_v[i] && !push) begin
                    push     = 1'b1;
                    sel      = 2'(i);
                    drain[i] = 1'b1;
                end
            end
        end
    end

    assign drop_any = |(emit & pend_v & ~drain);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pend_v   <= '0;
            evt_drop <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                pend_code[i] <= '0;
            end
        end else begin
            evt_drop <= drop_any;
            for (int unsigned i = 0; i < 4; i++) begin
                if (emit[i] && (!pend_v[i] || drain[i])) begin
                    pend_v[i]    <= 1'b1;
                    pend_code[i] <= {etype[i], 2'(i)};
                end else if (drain[i]) begin
                    pend_v[i] <= 1'b0;
                end
            end
        end
    end

    assign pop = cmd_valid && cmd_ready;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= pend_code[sel];
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            if (push && !pop) begin
                level <= level + 3'd1;
            end else if (!push && pop) begin
                level <= level - 3'd1;
            end
        end
    end

    assign cmd_valid = (level != 3'd0);
    assign cmd_code  = cmd_valid ? mem[rd_ptr] : 4'h0;
    assign cmd_level = level;

endmodule

// File: tb/tb_key_cmd_decoder.sv
// Bench for key_cmd_decoder: hold-time based event model plus a queue FIFO,
// compared every cycle, with directed scenarios pinned by literal expectations.
module tb_key_cmd_decoder;

    localparam int LCNT = 100;
    localparam int RCNT = 20;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [3:0] kf;
    logic [3:0] kv;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_code;
    logic [2:0] cmd_level;
    logic       evt_drop;

    int total = 0;
    int bad   = 0;

    key_cmd_decoder #(.LONG_CNT(32'd100), .REPEAT_CNT(32'd20)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_flag0 (kf[0]),
        .key_flag1 (kf[1]),
        .key_flag2 (kf[2]),
        .key_flag3 (kf[3]),
        .key_value0(kv[0]),
        .key_value1(kv[1]),
        .key_value2(kv[2]),
        .key_value3(kv[3]),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_code  (cmd_code),
        .cmd_level (cmd_level),
        .evt_drop  (evt_drop)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: mode 0 idle, 1 held, 2 long; events derived from cycles elapsed since the press.
    int         cyc = 0;
    int         m_mode  [4] = '{0, 0, 0, 0};
    int         m_press [4] = '{0, 0, 0, 0};
    bit         m_pend_v[4] = '{0, 0, 0, 0};
    logic [3:0] m_pend_code[4];
    logic [3:0] m_q[$];
    bit         m_drop = 1'b0;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < 4; k++) begin
                m_mode[k]   = 0;
                m_pend_v[k] = 1'b0;
            end
            m_q.delete();
            m_drop = 1'b0;
            if (sys_clk) cyc++;
        end else begin
            bit         ev [4];
            logic [1:0] ty [4];
            int         hold;
            int         pick;
            bit         dr;
            for (int k = 0; k < 4; k++) begin
                ev[k] = 1'b0;
                ty[k] = 2'b00;
                hold  = cyc - m_press[k];
                if (m_mode[k] == 0) begin
                    if (kf[k] && !kv[k]) begin
                        m_mode[k]  = 1;
                        m_press[k] = cyc;
                    end
                end else if (kf[k] && kv[k]) begin
                    ev[k]     = 1'b1;
                    ty[k]     = (m_mode[k] == 1) ? 2'b00 : 2'b11;
                    m_mode[k] = 0;
                end else if (m_mode[k] == 1 && hold == LCNT) begin
                    ev[k]     = 1'b1;
                    ty[k]     = 2'b01;
                    m_mode[k] = 2;
                end else if (m_mode[k] == 2 && hold > LCNT && (hold - LCNT) % RCNT == 0) begin
                    ev[k] = 1'b1;
                    ty[k] = 2'b10;
                end
            end
            pick = -1;
            if (m_q.size() < 4)
                for (int k = 3; k >= 0; k--)
                    if (m_pend_v[k]) pick = k;
            if (m_q.size() != 0 && cmd_ready) void'(m_q.pop_front());
            if (pick >= 0) begin
                m_q.push_back(m_pend_code[pick]);
                m_pend_v[pick] = 1'b0;
            end
            dr = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (ev[k]) begin
                    if (m_pend_v[k]) dr = 1'b1;
                    else begin
                        m_pend_v[k]    = 1'b1;
                        m_pend_code[k] = {ty[k], 2'(k)};
                    end
                end
            end
            m_drop = dr;
            cyc++;
        end
    end

    bit         cmp_en = 1'b0;
    logic [3:0] log_q[$];
    int         log_cyc[$];
    int         drop_cnt = 0;

    always @(negedge sys_clk) begin
        if (cmp_en) begin
            check("valid", {31'd0, cmd_valid}, {31'd0, m_q.size() != 0});
            check("level", {29'd0, cmd_level}, m_q.size());
            check("code", {28'd0, cmd_code}, (m_q.size() != 0) ? {28'd0, m_q[0]} : 32'd0);
            check("drop", {31'd0, evt_drop}, {31'd0, m_drop});
        end
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            log_q.push_back(cmd_code);
            log_cyc.push_back(cyc);
        end
        if (evt_drop === 1'b1) drop_cnt++;
    end

    function automatic logic [31:0] log_at(input int i);
        if (i < log_q.size()) return {28'd0, log_q[i]};
        return 32'hDEAD;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic clear_log();
        log_q.delete();
        log_cyc.delete();
    endtask

    task automatic press(input int k);
        kf[k] = 1'b1;
        kv[k] = 1'b0;
        tick();
        kf[k] = 1'b0;
    endtask

    task automatic release_key(input int k);
        kf[k] = 1'b1;
        kv[k] = 1'b1;
        tick();
        kf[k] = 1'b0;
    endtask

    int seq_keys [7] = '{0, 1, 2, 3, 0, 1, 0};
    int seq_exp  [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        kf = '0;
        kv = '1;
        cmd_ready = 1'b1;
        sys_rst_n = 1'b0;
        tick(3);
        check("rst_valid", {31'd0, cmd_valid}, 0);
        check("rst_level", {29'd0, cmd_level}, 0);
        check("rst_code", {28'd0, cmd_code}, 0);
        check("rst_drop", {31'd0, evt_drop}, 0);
        sys_rst_n = 1'b1;
        cmp_en = 1'b1;
        tick(2);

        // Key1 short press, latency of two cycles after the release flag
        clear_log();
        press(1);
        tick(49);
        release_key(1);
        check("s1_c1_valid", {31'd0, cmd_valid}, 0);
        tick();
        check("s1_c2_valid", {31'd0, cmd_valid}, 1);
        check("s1_c2_code", {28'd0, cmd_code}, 4'b0001);
        tick(5);
        check("s1_count", log_q.size(), 1);
        check("s1_cmd0", log_at(0), 4'b0001);

        // Key2 long hold with two repeats
        clear_log();
        press(2);
        tick(144);
        release_key(2);
        tick(6);
        check("s2_count", log_q.size(), 4);
        check("s2_cmd0", log_at(0), 4'b0110);
        check("s2_cmd1", log_at(1), 4'b1010);
        check("s2_cmd2", log_at(2), 4'b1010);
        check("s2_cmd3", log_at(3), 4'b1110);

        // Key0 and key3 released together
        clear_log();
        kf[0] = 1'b1; kv[0] = 1'b0;
        kf[3] = 1'b1; kv[3] = 1'b0;
        tick();
        kf = '0;
        tick(10);
        kf[0] = 1'b1; kv[0] = 1'b1;
        kf[3] = 1'b1; kv[3] = 1'b1;
        tick();
        kf = '0;
        tick(6);
        check("s3_count", log_q.size(), 2);
        check("s3_cmd0", log_at(0), 4'b0000);
        check("s3_cmd1", log_at(1), 4'b0011);
        if (log_cyc.size() == 2) check("s3_consec", log_cyc[1] - log_cyc[0], 1);
        else check("s3_consec_len", log_cyc.size(), 2);

        // FIFO saturation with consumer stalled
        clear_log();
        cmd_ready = 1'b0;
        drop_cnt  = 0;
        for (int e = 0; e < 7; e++) begin
            press(seq_keys[e]);
            tick(2);
            release_key(seq_keys[e]);
            tick(3);
            if (e == 3) begin
                check("s4_full_level", {29'd0, cmd_level}, 4);
                check("s4_full_head", {28'd0, cmd_code}, 4'b0000);
            end
        end
        check("s4_level", {29'd0, cmd_level}, 4);
        check("s4_valid", {31'd0, cmd_valid}, 1);
        check("s4_head", {28'd0, cmd_code}, 4'b0000);
        check("s4_drops", drop_cnt, 1);
        cmd_ready = 1'b1;
        tick(12);
        check("s4_count", log_q.size(), 6);
        for (int i = 0; i < 6; i++) check("s4_order", log_at(i), seq_exp[i]);
        check("s4_empty", {29'd0, cmd_level}, 0);

        // Release lands on the long-press terminal count
        clear_log();
        press(0);
        tick(99);
        release_key(0);
        tick(6);
        check("s5_count", log_q.size(), 1);
        check("s5_cmd0", log_at(0), 4'b0000);

        // Reset while key1 is long-held with two commands queued
        clear_log();
        cmd_ready = 1'b0;
        press(1);
        tick(3);
        press(0);
        tick(2);
        release_key(0);
        tick(102);
        check("s6_pre_level", {29'd0, cmd_level}, 2);
        check("s6_pre_head", {28'd0, cmd_code}, 4'b0000);
        sys_rst_n = 1'b0;
        #1;
        check("s6_rst_valid", {31'd0, cmd_valid}, 0);
        check("s6_rst_level", {29'd0, cmd_level}, 0);
        check("s6_rst_code", {28'd0, cmd_code}, 0);
        tick(2);
        sys_rst_n = 1'b1;
        cmd_ready = 1'b1;
        clear_log();
        release_key(1);
        tick(6);
        check("s6_post_count", log_q.size(), 0);
        check("s6_post_valid", {31'd0, cmd_valid}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
